// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray sweep sequencer.
// Holds the FSM state encoding and a width-independent one-hot test.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/gray_codE.sv
// Combinational binary-to-Gray converter.
// Pure logic so the Gray value tracks its binary input in the same cycle.
module gray_codE #(
  parameter int N = 4
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Sweeps a binary range, streaming (binary, Gray) pairs over valid/ready.
// Adds transfer counting, stop/abort and a Gray adjacency checker.
module gray_sweep_ctrl
  import gray_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          dir,
  input  logic          wrap,
  input  logic [N-1:0]  lo,
  input  logic [N-1:0]  hi,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_bin,
  output logic [N-1:0]  out_gray,
  output logic          busy,
  output logic          done,
  output logic          range_err,
  output logic          adj_err,
  output logic [CW-1:0] xfer_cnt
);

  sweep_state_t state, state_nxt;

  logic [N-1:0] cnt;
  logic [N-1:0] lo_r;
  logic [N-1:0] hi_r;
  logic         dir_r;
  logic         wrap_r;
  logic [N-1:0] prev_gray;
  logic         prev_vld;

  logic         xfer;
  logic         at_term;
  logic         full_rng;
  logic [N-1:0] diff;
  logic         adj_ok;

  gray_codE #(.N(N)) u_gray (
    .bin  (cnt),
    .gray (out_gray)
  );

  assign out_bin  = cnt;
  assign xfer     = (state == RUN) && out_ready;
  assign at_term  = dir_r ? (cnt == lo_r) : (cnt == hi_r);
  assign full_rng = (lo_r == '0) && (hi_r == '1);
  assign diff     = out_gray ^ prev_gray;
  assign adj_ok   = is_one_hot(32'(diff));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (lo > hi) ? DONE : RUN;
      end
      RUN: begin
        if (stop)
          state_nxt = IDLE;
        else if (xfer && at_term && !wrap_r)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
      dir_r     <= 1'b0;
      wrap_r    <= 1'b0;
      range_err <= 1'b0;
      adj_err   <= 1'b0;
      xfer_cnt  <= '0;
      prev_gray <= '0;
      prev_vld  <= 1'b0;
    end else if (state == IDLE && start) begin
      lo_r      <= lo;
      hi_r      <= hi;
      dir_r     <= dir;
      wrap_r    <= wrap;
      adj_err   <= 1'b0;
      xfer_cnt  <= '0;
      prev_vld  <= 1'b0;
      range_err <= (lo > hi);
      if (lo <= hi) cnt <= dir ? hi : lo;
    end else if (xfer) begin
      if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + CW'(1);
      if (prev_vld && !adj_ok) adj_err <= 1'b1;
      prev_gray <= out_gray;
      prev_vld  <= 1'b1;
      if (!at_term) begin
        cnt <= dir_r ? cnt - N'(1) : cnt + N'(1);
      end else if (wrap_r) begin
        cnt <= dir_r ? hi_r : lo_r;
        // a partial-range reload is a deliberate jump, so skip its check
        if (!full_rng) prev_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Directed self-checking bench for gray_sweep_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_gray_sweep_ctrl;

  localparam int N  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, dir, wrap, out_ready;
  logic [N-1:0]  lo, hi;
  logic          out_valid, busy, done, range_err, adj_err;
  logic [N-1:0]  out_bin, out_gray;
  logic [CW-1:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_sweep_ctrl #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .wrap      (wrap),
    .lo        (lo),
    .hi        (hi),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_gray  (out_gray),
    .busy      (busy),
    .done      (done),
    .range_err (range_err),
    .adj_err   (adj_err),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [N-1:0] l, input logic [N-1:0] h,
                    input logic d, input logic w);
    lo = l; hi = h; dir = d; wrap = w; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [3:0] g1 [4]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
  logic [3:0] b2 [3]  = '{4'd7, 4'd6, 4'd5};
  logic [3:0] g2 [3]  = '{4'b0100, 4'b0101, 4'b0111};
  logic [3:0] g3 [8]  = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                          4'b0110, 4'b0111, 4'b0101, 4'b0100};
  logic [3:0] g6 [3]  = '{4'b0011, 4'b0010, 4'b0110};

  initial begin
    rst = 1'b1; start = 0; stop = 0; dir = 0; wrap = 0;
    out_ready = 1; lo = 0; hi = 0;
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_rerr",  32'(range_err), 0);
    chk("rst_aerr",  32'(adj_err), 0);
    chk("rst_cnt",   32'(xfer_cnt), 0);
    chk("rst_bin",   32'(out_bin), 0);
    rst = 1'b0;
    tick();

    // 1: 0..3 up, one-shot
    go(4'd0, 4'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", 32'(out_valid), 1);
      chk("t1_gray",  32'(out_gray), 32'(g1[i]));
      tick();
    end
    chk("t1_done",  32'(done), 1);
    chk("t1_valid0", 32'(out_valid), 0);
    chk("t1_cnt",   32'(xfer_cnt), 4);
    chk("t1_aerr",  32'(adj_err), 0);
    tick();
    chk("t1_done1", 32'(done), 0);

    // 2: 5..7 down
    go(4'd5, 4'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_bin",  32'(out_bin), 32'(b2[i]));
      chk("t2_gray", 32'(out_gray), 32'(g2[i]));
      tick();
    end
    chk("t2_done", 32'(done), 1);
    chk("t2_cnt",  32'(xfer_cnt), 3);
    tick();

    // 3: backpressure hold
    go(4'd0, 4'd7, 1'b0, 1'b0);
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hbin",  32'(out_bin), 2);
      chk("t3_hgray", 32'(out_gray), 32'b0011);
      chk("t3_hval",  32'(out_valid), 1);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 8; i++) begin
      chk("t3_gray", 32'(out_gray), 32'(g3[i]));
      tick();
    end
    chk("t3_done", 32'(done), 1);
    chk("t3_cnt",  32'(xfer_cnt), 8);
    tick();

    // 4: full-range wrap then stop at 4
    go(4'd0, 4'd15, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    chk("t4_b15", 32'(out_bin), 15);
    chk("t4_g15", 32'(out_gray), 32'b1000);
    tick();
    chk("t4_b0",  32'(out_bin), 0);
    chk("t4_g0",  32'(out_gray), 0);
    chk("t4_val", 32'(out_valid), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t4_b4", 32'(out_bin), 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_sval",  32'(out_valid), 0);
    chk("t4_sbusy", 32'(busy), 0);
    chk("t4_sdone", 32'(done), 0);
    chk("t4_cnt",   32'(xfer_cnt), 21);
    chk("t4_aerr",  32'(adj_err), 0);
    tick();
    chk("t4_sdone2", 32'(done), 0);

    // 5: range error, start during done ignored
    go(4'd9, 4'd3, 1'b0, 1'b0);
    chk("t5_rerr", 32'(range_err), 1);
    chk("t5_done", 32'(done), 1);
    chk("t5_val",  32'(out_valid), 0);
    chk("t5_cnt",  32'(xfer_cnt), 0);
    go(4'd0, 4'd3, 1'b0, 1'b0);
    chk("t5_ign_val",  32'(out_valid), 0);
    chk("t5_ign_done", 32'(done), 0);
    tick();
    chk("t5_ign_val2", 32'(out_valid), 0);
    chk("t5_rerr2",    32'(range_err), 1);

    // 6: async reset mid-sweep
    go(4'd0, 4'd7, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_b6", 32'(out_bin), 6);
    #2 rst = 1'b1;
    #1;
    chk("t6_val",  32'(out_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_cnt",  32'(xfer_cnt), 0);
    chk("t6_bin",  32'(out_bin), 0);
    #1 rst = 1'b0;
    tick();
    go(4'd2, 4'd4, 1'b0, 1'b0);
    chk("t6_rerr", 32'(range_err), 0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_gray", 32'(out_gray), 32'(g6[i]));
      tick();
    end
    chk("t6_fdone", 32'(done), 1);
    chk("t6_fcnt",  32'(xfer_cnt), 3);
    tick();

    // single-value wrap repeats without adjacency error
    go(4'd6, 4'd6, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("sv_bin", 32'(out_bin), 6);
      tick();
    end
    chk("sv_aerr", 32'(adj_err), 0);
    chk("sv_cnt",  32'(xfer_cnt), 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sv_val", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
